// File: rtl/irig_pkg.sv
// Shared IRIG-B frame definitions: symbol codes, sequencer states, field bit positions.
package irig_pkg;

    typedef enum logic [1:0] {
        SYM_ZERO = 2'b00,
        SYM_ONE  = 2'b01,
        SYM_MARK = 2'b10,
        SYM_BAD  = 2'b11
    } sym_t;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        ARM   = 2'd1,
        TRACK = 2'd2
    } state_t;

    localparam int FRAME_LEN = 100;
    localparam int IDX_W     = 7;

    localparam int SEC_W  = 7;
    localparam int MIN_W  = 7;
    localparam int HOUR_W = 6;
    localparam int DAY_W  = 10;

    // LSB-first bit positions of each BCD digit within the frame
    localparam int SEC_UNITS_LSB  = 1;
    localparam int SEC_TENS_LSB   = 6;
    localparam int MIN_UNITS_LSB  = 10;
    localparam int MIN_TENS_LSB   = 15;
    localparam int HOUR_UNITS_LSB = 20;
    localparam int HOUR_TENS_LSB  = 25;
    localparam int DAY_UNITS_LSB  = 30;
    localparam int DAY_TENS_LSB   = 35;
    localparam int DAY_HUND_LSB   = 40;

    // Frame reference (index 0) and position identifiers (every index ending in 9)
    function automatic logic is_marker_pos(input logic [IDX_W-1:0] idx);
        return (idx == 7'd0) || ((idx % 7'd10) == 7'd9);
    endfunction

endpackage

// File: rtl/irig_bcd_check.sv
// Combinational legality check of decoded time fields; zero latency, no flow control.
// ok is high only when every digit is decimal and each field is within its calendar range.
module irig_bcd_check
    import irig_pkg::*;
(
    input  logic [SEC_W-1:0]  sec,
    input  logic [MIN_W-1:0]  min,
    input  logic [HOUR_W-1:0] hour,
    input  logic [DAY_W-1:0]  day,
    output logic              ok
);

    logic sec_ok;
    logic min_ok;
    logic hour_ok;
    logic day_digits_ok;
    logic day_range_ok;

    assign sec_ok  = (sec[3:0] <= 4'd9) && (sec[6:4] <= 3'd5);
    assign min_ok  = (min[3:0] <= 4'd9) && (min[6:4] <= 3'd5);
    assign hour_ok = (hour[3:0] <= 4'd9) &&
                     ((hour[5:4] <= 2'd1) || ((hour[5:4] == 2'd2) && (hour[3:0] <= 4'd3)));

    assign day_digits_ok = (day[3:0] <= 4'd9) && (day[7:4] <= 4'd9);
    // Day of year 1..366: hundreds 3 only allowed up to 366
    assign day_range_ok  = (day != 10'd0) &&
                           ((day[9:8] <= 2'd2) ||
                            (day[7:4] <= 4'd5) ||
                            ((day[7:4] == 4'd6) && (day[3:0] <= 4'd6)));

    assign ok = sec_ok && min_ok && hour_ok && day_digits_ok && day_range_ok;

endmodule

// File: rtl/irig_frame_sequencer.sv
// IRIG-B frame sync, symbol indexing, BCD capture and once-per-frame time publish.
// Pulses/fields 1 clk after closing sym_valid; no backpressure, one symbol accepted per strobe.
module irig_frame_sequencer
    import irig_pkg::*;
#(
    parameter int MAX_ERR     = 3,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sym_valid,
    input  logic [1:0]        sym_type,
    output logic              locked,
    output logic [IDX_W-1:0]  sym_index,
    output logic              frame_valid,
    output logic              frame_err,
    output logic              sync_loss,
    output logic [SEC_W-1:0]  sec_bcd,
    output logic [MIN_W-1:0]  min_bcd,
    output logic [HOUR_W-1:0] hour_bcd,
    output logic [DAY_W-1:0]  day_bcd
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    state_t                 state;
    logic [FRAME_LEN-1:0]   cap;
    logic                   frame_bad;
    logic [3:0]             err_cnt;
    logic [TW-1:0]          tmo_cnt;

    logic [IDX_W-1:0]       idx_nxt;
    logic                   is_mark;
    logic                   sym_err;
    logic                   is_close;
    logic [3:0]             err_inc;
    logic                   err_limit;
    logic                   tmo_hit;

    logic [SEC_W-1:0]       f_sec;
    logic [MIN_W-1:0]       f_min;
    logic [HOUR_W-1:0]      f_hour;
    logic [DAY_W-1:0]       f_day;
    logic                   bcd_ok;
    logic                   unused_cap;

    assign idx_nxt   = (sym_index == IDX_W'(FRAME_LEN - 1)) ? '0 : sym_index + 1'b1;
    assign is_mark   = (sym_type == SYM_MARK);
    assign sym_err   = (sym_type == SYM_BAD) || (is_mark != is_marker_pos(idx_nxt));
    assign is_close  = is_mark && (idx_nxt == '0);
    assign err_inc   = (err_cnt == 4'hF) ? err_cnt : err_cnt + 4'd1;
    assign err_limit = (err_inc >= 4'(MAX_ERR));
    assign tmo_hit   = !sym_valid && (tmo_cnt == TMO_LAST);

    assign f_sec  = {cap[SEC_TENS_LSB  +: 3], cap[SEC_UNITS_LSB  +: 4]};
    assign f_min  = {cap[MIN_TENS_LSB  +: 3], cap[MIN_UNITS_LSB  +: 4]};
    assign f_hour = {cap[HOUR_TENS_LSB +: 2], cap[HOUR_UNITS_LSB +: 4]};
    assign f_day  = {cap[DAY_HUND_LSB  +: 2], cap[DAY_TENS_LSB   +: 4], cap[DAY_UNITS_LSB +: 4]};

    // Control-function and straight-binary bits are captured but never decoded
    assign unused_cap = ^cap;

    irig_bcd_check u_bcd_check (
        .sec  (f_sec),
        .min  (f_min),
        .hour (f_hour),
        .day  (f_day),
        .ok   (bcd_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            locked      <= 1'b0;
            sym_index   <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            sync_loss   <= 1'b0;
            sec_bcd     <= '0;
            min_bcd     <= '0;
            hour_bcd    <= '0;
            day_bcd     <= '0;
            cap         <= '0;
            frame_bad   <= 1'b0;
            err_cnt     <= '0;
            tmo_cnt     <= '0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            sync_loss   <= 1'b0;

            if (sym_valid) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != TMO_MAX) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            case (state)
                HUNT: begin
                    if (sym_valid && is_mark) begin
                        state <= ARM;
                    end
                end

                ARM: begin
                    // Second consecutive marker is Pr: start tracking at index 0
                    if (sym_valid && is_mark) begin
                        state     <= TRACK;
                        locked    <= 1'b1;
                        sym_index <= '0;
                        err_cnt   <= '0;
                        frame_bad <= 1'b0;
                    end else if (sym_valid || tmo_hit) begin
                        state <= HUNT;
                    end
                end

                TRACK: begin
                    if ((sym_valid && sym_err && err_limit) || tmo_hit) begin
                        state     <= HUNT;
                        locked    <= 1'b0;
                        sym_index <= '0;
                        sync_loss <= 1'b1;
                        err_cnt   <= '0;
                        frame_bad <= 1'b0;
                    end else if (sym_valid) begin
                        sym_index <= idx_nxt;
                        if (!sym_type[1]) begin
                            cap[idx_nxt] <= sym_type[0];
                        end
                        if (sym_err) begin
                            frame_bad <= 1'b1;
                            err_cnt   <= err_inc;
                        end else if (is_close) begin
                            frame_bad <= 1'b0;
                            if (!frame_bad && bcd_ok) begin
                                sec_bcd     <= f_sec;
                                min_bcd     <= f_min;
                                hour_bcd    <= f_hour;
                                day_bcd     <= f_day;
                                frame_valid <= 1'b1;
                                err_cnt     <= '0;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end
                    end
                end

                default: state <= HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_irig_frame_sequencer.sv
// Randomized bench for irig_frame_sequencer against a symbol-level reference model.
module tb_irig_frame_sequencer;

    localparam int MAX_ERR = 3;
    localparam int TMO     = 300;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sym_valid = 1'b0;
    logic [1:0] sym_type = 2'b00;
    logic       locked, frame_valid, frame_err, sync_loss;
    logic [6:0] sym_index, sec_bcd, min_bcd;
    logic [5:0] hour_bcd;
    logic [9:0] day_bcd;

    int n_tests = 0;
    int n_fail  = 0;
    int fv_cnt  = 0;
    int fe_cnt  = 0;
    int sl_cnt  = 0;

    irig_frame_sequencer #(.MAX_ERR(MAX_ERR), .TIMEOUT_CYC(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sym_valid   (sym_valid),
        .sym_type    (sym_type),
        .locked      (locked),
        .sym_index   (sym_index),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .sync_loss   (sync_loss),
        .sec_bcd     (sec_bcd),
        .min_bcd     (min_bcd),
        .hour_bcd    (hour_bcd),
        .day_bcd     (day_bcd)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [6:0] bcd2(input int v);
        return 7'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic logic [9:0] bcd3(input int v);
        return 10'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
    endfunction

    // Reference model: mode 0=hunting, 1=one marker seen, 2=tracking
    int m_mode = 0, m_idx = 0, m_err = 0, m_gap = 0;
    bit m_bad = 0;
    int m_bits [100];
    int m_sec = 0, m_min = 0, m_hour = 0, m_day = 0;
    bit e_fv = 0, e_fe = 0, e_sl = 0;

    function automatic int field(input int lsb, input int w);
        int v = 0;
        for (int k = 0; k < w; k++) v += m_bits[lsb + k] << k;
        return v;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_idx = 0; m_err = 0; m_gap = 0; m_bad = 0;
        m_sec = 0; m_min = 0; m_hour = 0; m_day = 0;
        e_fv = 0; e_fe = 0; e_sl = 0;
        for (int i = 0; i < 100; i++) m_bits[i] = 0;
    endtask

    task automatic model_close();
        int su, st, mu, mt, hu, ht, du, dt, dh, s, mi, h, d;
        bit legal;
        su = field(1, 4);  st = field(6, 3);
        mu = field(10, 4); mt = field(15, 3);
        hu = field(20, 4); ht = field(25, 2);
        du = field(30, 4); dt = field(35, 4); dh = field(40, 2);
        s = st * 10 + su; mi = mt * 10 + mu; h = ht * 10 + hu; d = dh * 100 + dt * 10 + du;
        legal = (su <= 9) && (mu <= 9) && (hu <= 9) && (du <= 9) && (dt <= 9) &&
                (s <= 59) && (mi <= 59) && (h <= 23) && (d >= 1) && (d <= 366);
        if (!m_bad && legal) begin
            m_sec = s; m_min = mi; m_hour = h; m_day = d;
            e_fv = 1;
            m_err = 0;
        end else begin
            e_fe = 1;
        end
        m_bad = 0;
    endtask

    task automatic model_step();
        int t, n;
        bit em, es;
        e_fv = 0; e_fe = 0; e_sl = 0;
        if (!sym_valid) begin
            m_gap++;
            if (m_gap == TMO) begin
                if (m_mode == 2) e_sl = 1;
                m_mode = 0;
            end
            return;
        end
        m_gap = 0;
        t = int'(sym_type);
        if (m_mode == 0) begin
            if (t == 2) m_mode = 1;
        end else if (m_mode == 1) begin
            if (t == 2) begin
                m_mode = 2; m_idx = 0; m_err = 0; m_bad = 0;
            end else begin
                m_mode = 0;
            end
        end else begin
            n  = (m_idx + 1) % 100;
            em = (n == 0) || (n % 10 == 9);
            es = (t == 3) || ((t == 2) != em);
            m_idx = n;
            if (t < 2) m_bits[n] = t;
            if (es) begin
                m_bad = 1;
                if (m_err < 15) m_err++;
                if (m_err >= MAX_ERR) begin
                    m_mode = 0;
                    e_sl = 1;
                end
            end else if (n == 0) begin
                model_close();
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("locked", 32'(locked), 32'(m_mode == 2));
            chk("sym_index", 32'(sym_index), (m_mode == 2) ? m_idx : 0);
            chk("frame_valid", 32'(frame_valid), 32'(e_fv));
            chk("frame_err", 32'(frame_err), 32'(e_fe));
            chk("sync_loss", 32'(sync_loss), 32'(e_sl));
            chk("sec_bcd", 32'(sec_bcd), 32'(bcd2(m_sec)));
            chk("min_bcd", 32'(min_bcd), 32'(bcd2(m_min)));
            chk("hour_bcd", 32'(hour_bcd), 32'(6'(bcd2(m_hour))));
            chk("day_bcd", 32'(day_bcd), 32'(bcd3(m_day)));
            if (rst_n) begin
                if (frame_valid) fv_cnt++;
                if (frame_err) fe_cnt++;
                if (sync_loss) sl_cnt++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    // Stimulus
    logic [1:0] fr [100];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] t, input int gap);
        repeat (gap) step();
        sym_valid = 1'b1;
        sym_type  = t;
        step();
        sym_valid = 1'b0;
        sym_type  = 2'($urandom_range(0, 3));
    endtask

    task automatic send_r(input logic [1:0] t);
        send(t, $urandom_range(0, 3));
    endtask

    task automatic build(input logic [6:0] s, input logic [6:0] mi, input logic [5:0] h, input logic [9:0] d);
        for (int i = 0; i < 100; i++)
            fr[i] = ((i == 0) || (i % 10 == 9)) ? 2'b10 : 2'($urandom_range(0, 1));
        for (int k = 0; k < 4; k++) begin
            fr[1 + k]  = {1'b0, s[k]};
            fr[10 + k] = {1'b0, mi[k]};
            fr[20 + k] = {1'b0, h[k]};
            fr[30 + k] = {1'b0, d[k]};
            fr[35 + k] = {1'b0, d[4 + k]};
        end
        for (int k = 0; k < 3; k++) begin
            fr[6 + k]  = {1'b0, s[4 + k]};
            fr[15 + k] = {1'b0, mi[4 + k]};
        end
        for (int k = 0; k < 2; k++) begin
            fr[25 + k] = {1'b0, h[4 + k]};
            fr[40 + k] = {1'b0, d[8 + k]};
        end
    endtask

    task automatic build_legal(output logic [6:0] s, output logic [6:0] mi, output logic [5:0] h, output logic [9:0] d);
        s  = bcd2(int'($urandom_range(0, 59)));
        mi = bcd2(int'($urandom_range(0, 59)));
        h  = 6'(bcd2(int'($urandom_range(0, 23))));
        d  = bcd3(int'($urandom_range(1, 366)));
        build(s, mi, h, d);
    endtask

    task automatic send_range(input int a, input int b);
        for (int i = a; i <= b; i++) send_r(fr[i]);
    endtask

    task automatic send_frame();
        send_range(1, 99);
        send_r(fr[0]);
    endtask

    initial begin
        logic [6:0] ls, lm;
        logic [5:0] lh;
        logic [9:0] ld;
        logic [6:0] ts, tm;
        logic [5:0] th;
        logic [9:0] td;
        int p1, p2, p3, c_fv, c_fe, c_sl;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_locked", 32'(locked), 0);
        chk("rst_index", 32'(sym_index), 0);
        chk("rst_sec", 32'(sec_bcd), 0);
        chk("rst_day", 32'(day_bcd), 0);
        rst_n = 1'b1;
        step();

        // 1: noise, lone marker, then P0,Pr and two frames of 12:34:56 day 123
        send_r(2'b00); send_r(2'b01); send_r(2'b10); send_r(2'b00); send_r(2'b11);
        chk("s1_not_locked", 32'(locked), 0);
        send_r(2'b10);
        send_r(2'b10);
        chk("s1_locked_after_pr", 32'(locked), 1);
        chk("s1_index0", 32'(sym_index), 0);
        build(7'h56, 7'h34, 6'h12, 10'h123);
        send_frame();
        chk("s1_fv_pulse", 32'(frame_valid), 1);
        chk("s1_sec", 32'(sec_bcd), 32'(7'h56));
        chk("s1_min", 32'(min_bcd), 32'(7'h34));
        chk("s1_hour", 32'(hour_bcd), 32'(6'h12));
        chk("s1_day", 32'(day_bcd), 32'(10'h123));
        build(7'h56, 7'h34, 6'h12, 10'h123);
        send_frame();
        step();
        chk("s1_fv_count", fv_cnt, 2);
        chk("s1_fe_count", fe_cnt, 0);

        // 2: data symbol where the index-49 marker belongs
        build_legal(ts, tm, th, td);
        fr[49] = 2'($urandom_range(0, 1));
        send_frame();
        chk("s2_frame_err", 32'(frame_err), 1);
        chk("s2_sec_hold", 32'(sec_bcd), 32'(7'h56));
        chk("s2_locked", 32'(locked), 1);
        build_legal(ls, lm, lh, ld);
        send_frame();
        chk("s2_fv_pulse", 32'(frame_valid), 1);
        chk("s2_sec", 32'(sec_bcd), 32'(ls));
        chk("s2_day", 32'(day_bcd), 32'(ld));
        step();

        // 3: three malformed symbols within one frame
        build_legal(ts, tm, th, td);
        p1 = 10 * $urandom_range(0, 2) + $urandom_range(1, 8);
        p2 = 30 + 10 * $urandom_range(0, 2) + $urandom_range(1, 8);
        p3 = 60 + 10 * $urandom_range(0, 2) + $urandom_range(1, 8);
        fr[p1] = 2'b11; fr[p2] = 2'b11; fr[p3] = 2'b11;
        c_sl = sl_cnt;
        send_range(1, p2);
        chk("s3_locked_after_2", 32'(locked), 1);
        send_range(p2 + 1, p3);
        chk("s3_sync_loss", 32'(sync_loss), 1);
        chk("s3_unlocked", 32'(locked), 0);
        chk("s3_index0", 32'(sym_index), 0);
        step();
        chk("s3_sl_count", sl_cnt, c_sl + 1);
        send_r(2'b00); send_r(2'b10); send_r(2'b01); send_r(2'b11);
        chk("s3_no_relock", 32'(locked), 0);
        send_r(2'b10); send_r(2'b10);
        chk("s3_relocked", 32'(locked), 1);
        build_legal(ls, lm, lh, ld);
        send_frame();
        chk("s3_fv_pulse", 32'(frame_valid), 1);

        // 4: gap one short of the threshold keeps lock, full gap drops it
        build_legal(ts, tm, th, td);
        send_range(1, 30);
        send(fr[31], TMO - 1);
        chk("s4_threshold_keeps", 32'(locked), 1);
        chk("s4_index", 32'(sym_index), 31);
        c_sl = sl_cnt;
        repeat (TMO + 5) step();
        chk("s4_timeout_unlock", 32'(locked), 0);
        chk("s4_sl_one_pulse", sl_cnt, c_sl + 1);
        send_r(2'b10); send_r(2'b10);
        build_legal(ls, lm, lh, ld);
        send_frame();
        chk("s4_fv_pulse", 32'(frame_valid), 1);

        // 5: sec units of 0xA rejects the frame, then random legal/illegal frames
        build({3'd2, 4'hA}, tm, th, td);
        send_frame();
        chk("s5_frame_err", 32'(frame_err), 1);
        chk("s5_sec_hold", 32'(sec_bcd), 32'(ls));
        for (int f = 0; f < 6; f++) begin
            if (m_mode != 2) begin
                send_r(2'b10); send_r(2'b10);
            end
            if ($urandom_range(0, 2) == 0)
                build(7'($urandom), 7'($urandom), 6'($urandom), 10'($urandom));
            else
                build_legal(ts, tm, th, td);
            if ($urandom_range(0, 3) == 0)
                fr[$urandom_range(1, 98)] = 2'($urandom_range(2, 3));
            send_frame();
        end

        // 6: asynchronous reset in the middle of a frame
        repeat (TMO + 2) step();
        send_r(2'b10); send_r(2'b10);
        build_legal(ts, tm, th, td);
        send_range(1, 57);
        chk("s6_index57", 32'(sym_index), 57);
        c_fv = fv_cnt; c_fe = fe_cnt; c_sl = sl_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_rst_locked", 32'(locked), 0);
        chk("s6_rst_index", 32'(sym_index), 0);
        chk("s6_rst_sec", 32'(sec_bcd), 0);
        chk("s6_rst_min", 32'(min_bcd), 0);
        chk("s6_rst_hour", 32'(hour_bcd), 0);
        chk("s6_rst_day", 32'(day_bcd), 0);
        chk("s6_rst_pulses", 32'({frame_valid, frame_err, sync_loss}), 0);
        step();
        repeat (2) step();
        rst_n = 1'b1;
        repeat (5) step();
        send_r(2'b00); send_r(2'b01);
        chk("s6_hunt", 32'(locked), 0);
        chk("s6_no_pulses", (fv_cnt - c_fv) + (fe_cnt - c_fe) + (sl_cnt - c_sl), 0);
        send_r(2'b10); send_r(2'b10);
        build(7'h07, 7'h59, 6'h23, 10'h366);
        send_frame();
        chk("s6_fv_pulse", 32'(frame_valid), 1);
        chk("s6_sec", 32'(sec_bcd), 32'(7'h07));
        chk("s6_hour", 32'(hour_bcd), 32'(6'h23));
        chk("s6_day", 32'(day_bcd), 32'(10'h366));
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
